// File: rtl/genqueue_drain.sv
// Queue read-side adapter: prefetches one wide word and serialises it into
// narrow valid/ready beats, least-significant chunk first.
module genqueue_drain #(
   parameter int WIDTH  = 64,
   parameter int OWIDTH = 8,
   parameter int CNTW   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              queue_empty,
   input  logic              queue_oready,
   input  logic [WIDTH-1:0]  queue_data_out,
   output logic              queue_re,
   output logic [OWIDTH-1:0] out_data,
   output logic              out_valid,
   output logic              out_last,
   input  logic              out_ready,
   output logic              busy,
   output logic [CNTW-1:0]   words_done
);

   localparam int CHUNKS = WIDTH / OWIDTH;
   localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);

   typedef enum logic {F_IDLE, F_WAIT} fstate_t;

   fstate_t           state, state_nxt;
   logic [WIDTH-1:0]  pbuf, sreg;
   logic              pbuf_valid, svalid;
   logic [CW-1:0]     cnt;
   logic              capture, accept, at_last, load;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= F_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         F_IDLE: if (!queue_empty && !pbuf_valid) state_nxt = F_WAIT;
         F_WAIT: if (queue_oready)                state_nxt = F_IDLE;
         default: state_nxt = F_IDLE;
      endcase
   end

   always_comb begin
      queue_re = (state == F_IDLE) && !queue_empty && !pbuf_valid;
      capture  = (state == F_WAIT) && queue_oready;
   end

   assign accept  = svalid & out_ready;
   assign at_last = (cnt == LAST);
   // Load uses the old pbuf even when a capture lands in the same cycle.
   assign load    = pbuf_valid & (!svalid | (accept & at_last));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pbuf       <= '0;
         pbuf_valid <= 1'b0;
      end else begin
         if (capture) pbuf <= queue_data_out;
         if (capture)   pbuf_valid <= 1'b1;
         else if (load) pbuf_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sreg       <= '0;
         cnt        <= '0;
         svalid     <= 1'b0;
         words_done <= '0;
      end else begin
         if (load) begin
            sreg   <= pbuf;
            cnt    <= '0;
            svalid <= 1'b1;
         end else if (accept) begin
            if (at_last) begin
               svalid <= 1'b0;
            end else begin
               sreg <= sreg >> OWIDTH;
               cnt  <= cnt + CW'(1);
            end
         end
         if (accept && at_last) words_done <= words_done + CNTW'(1);
      end
   end

   assign out_data  = sreg[OWIDTH-1:0];
   assign out_valid = svalid;
   assign out_last  = svalid & at_last;
   assign busy      = svalid | pbuf_valid | (state == F_WAIT);

endmodule

// File: tb/tb_genqueue_drain.sv
// Scoreboard bench for genqueue_drain: a latency-1 queue model feeds words,
// expected beats are queued at push time and checked by a separate monitor.
module tb_genqueue_drain;

   logic        clk = 1'b0;
   logic        rst;
   logic        queue_empty;
   logic        queue_oready;
   logic [63:0] queue_data_out;
   logic        queue_re;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_last;
   logic        out_ready;
   logic        busy;
   logic [3:0]  words_done;

   genqueue_drain #(.WIDTH(64), .OWIDTH(8), .CNTW(4)) dut (
      .clk(clk), .rst(rst),
      .queue_empty(queue_empty), .queue_oready(queue_oready),
      .queue_data_out(queue_data_out), .queue_re(queue_re),
      .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
      .out_ready(out_ready), .busy(busy), .words_done(words_done)
   );

   always #5 clk = ~clk;

   typedef struct packed {logic [7:0] d; logic l;} beat_t;

   beat_t       exp_q[$];
   logic [63:0] qmem[$];
   int          checks = 0;
   int          errors = 0;
   int          re_count = 0;
   int          beats_seen = 0;
   logic        re_seen = 1'b0;
   logic        spurious = 1'b0;
   logic        stalled_prev = 1'b0;
   int          wd = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [63:0] w);
      qmem.push_back(w);
      for (int i = 0; i < 8; i++) exp_q.push_back({w[i*8 +: 8], 1'(i == 7)});
      wd++;
   endtask

   task automatic wait_idle(input int max);
      int n = 0;
      while (!(exp_q.size() == 0 && qmem.size() == 0 && !busy) && n < max) begin
         tick();
         n++;
      end
      checks++;
      if (n >= max) begin
         errors++;
         $display("FAIL wait_idle timeout: got %0d cycles expected < %0d", n, max);
      end
   endtask

   task automatic wait_beats(input int target, input int max);
      int n = 0;
      while (beats_seen < target && n < max) begin
         tick();
         n++;
      end
      checks++;
      if (n >= max) begin
         errors++;
         $display("FAIL wait_beats timeout: got %0d beats expected %0d", beats_seen, target);
      end
   endtask

   task automatic check_gapless(input string name, input int nbeats);
      int n = 0;
      int gaps = 0;
      @(negedge clk);
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      for (int i = 0; i < nbeats; i++) begin
         if (!out_valid) gaps++;
         if (i != nbeats - 1) @(negedge clk);
      end
      check(name, 64'(gaps), 64'd0);
      #6;
   endtask

   // Queue model: one-cycle read latency, responds to queue_re seen before the edge.
   always @(negedge clk) begin
      re_seen = queue_re;
      if (queue_re) re_count++;
   end

   initial begin
      queue_empty    = 1'b1;
      queue_oready   = 1'b0;
      queue_data_out = '0;
      forever begin
         @(posedge clk);
         #1;
         queue_oready   = 1'b0;
         queue_data_out = '0;
         if (rst && re_seen && qmem.size() > 0) begin
            queue_data_out = qmem.pop_front();
            queue_oready   = 1'b1;
         end else if (spurious) begin
            queue_data_out = 64'hDEAD_BEEF_0BAD_F00D;
            queue_oready   = 1'b1;
            spurious       = 1'b0;
         end
         queue_empty = (qmem.size() == 0);
      end
   end

   // Monitor: compare every presented beat against the scoreboard head.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            if (stalled_prev) check("valid_held", 64'(out_valid), 64'd1);
            if (out_valid) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_beat: got %0h expected no beat", out_data);
               end else begin
                  check("beat_data", 64'(out_data), 64'(exp_q[0].d));
                  check("beat_last", 64'(out_last), 64'(exp_q[0].l));
                  if (out_ready) begin
                     void'(exp_q.pop_front());
                     beats_seen++;
                  end
               end
            end
            stalled_prev = out_valid && !out_ready;
         end else begin
            stalled_prev = 1'b0;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0, b0;
      rst       = 1'b0;
      out_ready = 1'b1;
      #2;
      check("rst_queue_re", 64'(queue_re), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_last", 64'(out_last), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_words_done", 64'(words_done), 64'd0);
      repeat (3) tick();
      #2 rst = 1'b1;
      tick();

      // single word
      r0 = re_count;
      push_word(64'h8877665544332211);
      check_gapless("single_gapless", 8);
      wait_idle(100);
      check("single_re_pulses", 64'(re_count - r0), 64'd1);
      check("single_words_done", 64'(words_done), 64'(wd % 16));
      check("single_busy", 64'(busy), 64'd0);

      // back-to-back
      r0 = re_count;
      push_word(64'h0123456789ABCDEF);
      push_word(64'hFEDCBA9876543210);
      push_word(64'h00FF00FF55AA55AA);
      push_word(64'hC3C3A5A5F0F00F0F);
      check_gapless("b2b_gapless", 32);
      wait_idle(200);
      check("b2b_re_pulses", 64'(re_count - r0), 64'd4);
      check("b2b_words_done", 64'(words_done), 64'(wd % 16));

      // backpressure at beat 3
      r0 = re_count;
      b0 = beats_seen;
      push_word(64'h8877665544332211);
      push_word(64'h1122334455667788);
      push_word(64'hA1B2C3D4E5F60718);
      wait_beats(b0 + 2, 50);
      out_ready = 1'b0;
      repeat (5) tick();
      check("bp_no_extra_re", 64'(re_count - r0), 64'd2);
      check("bp_busy", 64'(busy), 64'd1);
      check("bp_stall_data", 64'(out_data), 64'h33);
      out_ready = 1'b1;
      wait_idle(200);
      check("bp_re_pulses", 64'(re_count - r0), 64'd3);
      check("bp_words_done", 64'(words_done), 64'(wd % 16));

      // empty queue
      for (int i = 0; i < 20; i++) begin
         tick();
         check("empty_queue_re", 64'(queue_re), 64'd0);
         check("empty_out_valid", 64'(out_valid), 64'd0);
         check("empty_busy", 64'(busy), 64'd0);
      end

      // reset mid-word, asserted between clock edges
      b0 = beats_seen;
      push_word(64'h0807060504030201);
      wait_beats(b0 + 2, 50);
      #3 rst = 1'b0;
      #1;
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_out_last", 64'(out_last), 64'd0);
      check("midrst_out_data", 64'(out_data), 64'd0);
      check("midrst_queue_re", 64'(queue_re), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_words_done", 64'(words_done), 64'd0);
      exp_q.delete();
      qmem.delete();
      wd = 0;
      repeat (2) tick();
      #2 rst = 1'b1;
      tick();
      r0 = re_count;
      push_word(64'h1122334455667788);
      check_gapless("postrst_gapless", 8);
      wait_idle(100);
      check("postrst_words_done", 64'(words_done), 64'(wd % 16));
      check("postrst_re_pulses", 64'(re_count - r0), 64'd1);

      // counter wrap with 17 words
      #2 rst = 1'b0;
      wd = 0;
      tick();
      #2 rst = 1'b1;
      tick();
      r0 = re_count;
      for (int i = 0; i < 17; i++)
         push_word({32'(i) * 32'h01010101 ^ 32'hA5A5A5A5, 32'(i) + 32'h10203040});
      wait_idle(600);
      check("wrap_words_done", 64'(words_done), 64'd1);
      check("wrap_re_pulses", 64'(re_count - r0), 64'd17);

      // spurious read response while idle
      b0 = beats_seen;
      r0 = re_count;
      spurious = 1'b1;
      repeat (20) tick();
      check("spur_no_beats", 64'(beats_seen - b0), 64'd0);
      check("spur_busy", 64'(busy), 64'd0);
      check("spur_out_valid", 64'(out_valid), 64'd0);
      check("spur_words_done", 64'(words_done), 64'd1);
      check("spur_no_re", 64'(re_count - r0), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
